// File: rtl/carrier_gen_16bits.sv
// rtl/carrier_gen_16bits.sv - PWM carrier counter with shadowed period, up/down/up-down modes and phase sync
// Optional feature macro: CARRIER_PRESCALER_EN (adds the prescale port and tick prescaler)
module carrier_gen_16bits #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_onoff,
    input  logic [WIDTH-1:0] period,
    input  logic [1:0]       mode,
    input  logic [1:0]       mask_sel,
    input  logic [WIDTH-1:0] phase,
    input  logic             sync_dir,
    input  logic             sync_in,
`ifdef CARRIER_PRESCALER_EN
    input  logic [7:0]       prescale,
`endif
    output logic [WIDTH-1:0] carrier,
    output logic             dir_up,
    output logic             zero_evt,
    output logic             period_evt,
    output logic             maskevent,
    output logic             sync_out
);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UPDN = 2'b10;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] carrier_q, carrier_d;
    logic             dir_q, dir_d;
    logic             zero_q, zero_d;
    logic             pevt_q, pevt_d;
    logic             mask_q, mask_d;
    logic [WIDTH-1:0] pa_q, pa_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       msel_q, msel_d;
`ifdef CARRIER_PRESCALER_EN
    logic [7:0]       ps_a_q, ps_a_d;
    logic [7:0]       ps_cnt_q, ps_cnt_d;
`endif

    logic             tick;
    logic             up_mv;
    logic             wrap;
    logic [WIDTH-1:0] nxt;
    logic             nxt_dir;
    logic [WIDTH-1:0] sync_val;

    // Next-state: idle shadowing, sync load, and per-mode counting with cycle-boundary shadow loads
    always_comb begin
        state_d   = pwm_onoff ? ST_RUN : ST_IDLE;
        carrier_d = carrier_q;
        dir_d     = dir_q;
        zero_d    = 1'b0;
        pevt_d    = 1'b0;
        pa_d      = pa_q;
        mode_d    = mode_q;
        msel_d    = msel_q;
`ifdef CARRIER_PRESCALER_EN
        ps_a_d    = ps_a_q;
        ps_cnt_d  = ps_cnt_q;
        tick      = (ps_cnt_q >= ps_a_q);
`else
        tick      = 1'b1;
`endif
        up_mv     = 1'b1;
        wrap      = 1'b0;
        nxt       = carrier_q;
        nxt_dir   = dir_q;
        sync_val  = (phase > pa_q) ? pa_q : phase;

        // Candidate next count; wrap marks the tick that starts a new carrier cycle
        case (mode_q)
            MODE_DOWN: begin
                nxt_dir = 1'b0;
                if (carrier_q == '0 || carrier_q > pa_q) begin
                    // Reload takes the freshly shadowed period so a write on this edge is captured
                    nxt  = period;
                    wrap = 1'b1;
                end else begin
                    nxt = carrier_q - WIDTH'(1);
                end
            end
            MODE_UPDN: begin
                up_mv = dir_q;
                if (dir_q && carrier_q >= pa_q) begin
                    up_mv = 1'b0;
                end else if (!dir_q && carrier_q == '0) begin
                    up_mv = 1'b1;
                end
                if (pa_q == '0) begin
                    nxt = '0;
                end else if (up_mv) begin
                    nxt = carrier_q + WIDTH'(1);
                end else begin
                    nxt = carrier_q - WIDTH'(1);
                end
                // Direction flips on the tick that lands on an extreme
                if (nxt == '0) begin
                    nxt_dir = 1'b1;
                end else if (nxt == pa_q) begin
                    nxt_dir = 1'b0;
                end else begin
                    nxt_dir = up_mv;
                end
                wrap = (nxt == '0);
            end
            default: begin
                nxt_dir = 1'b1;
                if (carrier_q >= pa_q) begin
                    nxt  = '0;
                    wrap = 1'b1;
                end else begin
                    nxt = carrier_q + WIDTH'(1);
                end
            end
        endcase

        if (state_d == ST_IDLE) begin
            pa_d      = period;
            mode_d    = mode;
            msel_d    = mask_sel;
            carrier_d = (mode == MODE_DOWN) ? period : '0;
            dir_d     = (mode != MODE_DOWN);
`ifdef CARRIER_PRESCALER_EN
            ps_a_d    = prescale;
            ps_cnt_d  = '0;
`endif
        end else if (sync_in && state_q == ST_RUN) begin
            carrier_d = sync_val;
            dir_d     = (mode_q == MODE_UPDN) ? sync_dir : (mode_q != MODE_DOWN);
            zero_d    = (sync_val == '0);
            pevt_d    = (sync_val == pa_q);
`ifdef CARRIER_PRESCALER_EN
            ps_cnt_d  = '0;
`endif
        end else if (tick) begin
            carrier_d = nxt;
            dir_d     = nxt_dir;
            if (wrap) begin
                pa_d   = period;
                mode_d = mode;
                msel_d = mask_sel;
`ifdef CARRIER_PRESCALER_EN
                ps_a_d = prescale;
`endif
            end
            zero_d = (nxt == '0);
            pevt_d = (nxt == pa_d);
`ifdef CARRIER_PRESCALER_EN
            ps_cnt_d = '0;
`endif
        end else begin
`ifdef CARRIER_PRESCALER_EN
            ps_cnt_d = ps_cnt_q + 8'd1;
`endif
        end

        mask_d = (msel_d[0] & zero_d) | (msel_d[1] & pevt_d);
    end

    // State, active shadow copies and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            carrier_q <= '0;
            dir_q     <= 1'b1;
            zero_q    <= 1'b0;
            pevt_q    <= 1'b0;
            mask_q    <= 1'b0;
            pa_q      <= '0;
            mode_q    <= 2'b00;
            msel_q    <= 2'b00;
`ifdef CARRIER_PRESCALER_EN
            ps_a_q    <= '0;
            ps_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            carrier_q <= carrier_d;
            dir_q     <= dir_d;
            zero_q    <= zero_d;
            pevt_q    <= pevt_d;
            mask_q    <= mask_d;
            pa_q      <= pa_d;
            mode_q    <= mode_d;
            msel_q    <= msel_d;
`ifdef CARRIER_PRESCALER_EN
            ps_a_q    <= ps_a_d;
            ps_cnt_q  <= ps_cnt_d;
`endif
        end
    end

    assign carrier    = carrier_q;
    assign dir_up     = dir_q;
    assign zero_evt   = zero_q;
    assign period_evt = pevt_q;
    assign maskevent  = mask_q;
    assign sync_out   = zero_q;

endmodule
